// File: rtl/imem_load_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory load arbiter.
// IMEM_CSUM_EN (see top) enables the load checksum accumulator.
package imem_pkg;
    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 12;
    localparam int LEN_W_DEF = 13;

    localparam logic [31:0] NOP_INST = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/imem_load_arbiter_if.sv
// Bundle of loader, fetch and memory-side signals around the arbiter.
// slave = arbiter side, master = environment (fetch, loader, memory).
interface imem_load_arbiter_if #(
    parameter int DW    = 32,
    parameter int AW    = 12,
    parameter int LEN_W = 13
);
    logic             load_start;
    logic [AW-1:0]    load_base;
    logic [LEN_W-1:0] load_len;
    logic             ld_valid;
    logic [DW-1:0]    ld_data;
    logic             ld_ready;
    logic [31:0]      cpu_addr;
    logic [DW-1:0]    cpu_inst;
    logic             cpu_stall;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_we;
    logic [DW-1:0]    mem_rdata;
    logic             busy;
    logic             done;
    logic             err;
    logic [DW-1:0]    csum;

    modport slave (
        input  load_start, load_base, load_len,
        input  ld_valid, ld_data, cpu_addr, mem_rdata,
        output ld_ready, cpu_inst, cpu_stall,
        output mem_addr, mem_wdata, mem_we,
        output busy, done, err, csum
    );

    modport master (
        output load_start, load_base, load_len,
        output ld_valid, ld_data, cpu_addr, mem_rdata,
        input  ld_ready, cpu_inst, cpu_stall,
        input  mem_addr, mem_wdata, mem_we,
        input  busy, done, err, csum
    );
endinterface

// File: rtl/imem_load_arbiter_csum_acc.sv
// Modular-sum accumulator over words written during a load.
module imem_csum_acc #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] sum_o
);
    logic [DW-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i)
            sum_d = '0;
        else if (en_i)
            sum_d = sum_q + data_i;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sum_q <= '0;
        else
            sum_q <= sum_d;
    end

    assign sum_o = sum_q;
endmodule

// File: rtl/imem_load_arbiter.sv
// Shares single-port instruction memory between CPU fetch and a loader.
// Define IMEM_CSUM_EN to add a running checksum of loaded words on csum.
module imem_load_arbiter
    import imem_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input logic                clk,
    input logic                rst,
    imem_load_arbiter_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             csum_clr;
    logic [LEN_W:0]   end_w;

    // One extra bit so base+len can be compared against DEPTH without wrap
    assign end_w = (LEN_W+1)'(bus.load_base) + (LEN_W+1)'(bus.load_len);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        csum_clr      = 1'b0;
        bus.mem_addr  = ptr_q;
        bus.mem_wdata = bus.ld_data;
        bus.mem_we    = 1'b0;
        bus.cpu_inst  = DW'(NOP_INST);
        bus.cpu_stall = 1'b1;
        bus.ld_ready  = 1'b0;
        bus.busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.mem_addr  = bus.cpu_addr[AW+1:2];
                bus.cpu_inst  = bus.mem_rdata;
                bus.cpu_stall = 1'b0;
                if (bus.load_start) begin
                    if (bus.load_len == '0) begin
                        done_d   = 1'b1;
                        csum_clr = 1'b1;
                    end else if (end_w > (LEN_W+1)'(DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_d    = bus.load_base;
                        cnt_d    = bus.load_len;
                        csum_clr = 1'b1;
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
                bus.ld_ready = 1'b1;
                bus.busy     = 1'b1;
                if (bus.ld_valid) begin
                    bus.mem_we = 1'b1;
                    ptr_d      = ptr_q + 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.done = done_q;
    assign bus.err  = err_q;

`ifdef IMEM_CSUM_EN
    imem_csum_acc #(.DW(DW)) u_csum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (csum_clr),
        .en_i   (bus.mem_we),
        .data_i (bus.ld_data),
        .sum_o  (bus.csum)
    );
`else
    logic unused_clr;
    assign unused_clr = csum_clr;
    assign bus.csum   = '0;
`endif

    logic unused_addr;
    assign unused_addr = ^{bus.cpu_addr[31:AW+2], bus.cpu_addr[1:0]};
endmodule

// File: tb/tb_imem_load_arbiter.sv
// Randomized self-checking bench for imem_load_arbiter with a memory model.
module tb_imem_load_arbiter;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_load_arbiter_if bus ();

    imem_load_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_sum;
    logic [31:0] dq [$];
    int n_vec = 0;
    int n_err = 0;
    int wr_n  = 0;

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_n <= wr_n + 1;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_csum();
`ifdef IMEM_CSUM_EN
        return exp_sum;
`else
        return 32'h0;
`endif
    endfunction

    task automatic start(input logic [11:0] b, input logic [12:0] l);
        bus.load_start = 1'b1;
        bus.load_base  = b;
        bus.load_len   = l;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        logic [11:0] w;
        w = a[13:2];
        bus.cpu_addr = a;
        @(negedge clk);
        chk("f_addr", 64'(bus.mem_addr), 64'(w));
        chk("f_inst", 64'(bus.cpu_inst), 64'(ref_mem[w]));
        chk("f_stall", 64'(bus.cpu_stall), 64'(0));
        chk("f_busy", 64'(bus.busy), 64'(0));
        tick();
    endtask

    task automatic do_load(input logic [11:0] b, input logic [12:0] l,
                           input bit gaps);
        int w0;
        logic [11:0] a;
        logic [31:0] d;
        w0 = wr_n;
        exp_sum = '0;
        start(b, l);
        for (int i = 0; i < int'(l); i++) begin
            int g;
            g = gaps ? int'($urandom_range(0, 3)) : 0;
            for (int k = 0; k < g; k++) begin
                bus.ld_valid = 1'b0;
                @(negedge clk);
                chk("gap_we", 64'(bus.mem_we), 64'(0));
                chk("gap_inst", 64'(bus.cpu_inst), 64'(0));
                chk("gap_stall", 64'(bus.cpu_stall), 64'(1));
                tick();
            end
            d = (dq.size() > 0) ? dq.pop_front() : $urandom;
            a = b + 12'(i);
            bus.ld_valid = 1'b1;
            bus.ld_data  = d;
            @(negedge clk);
            chk("wr_we", 64'(bus.mem_we), 64'(1));
            chk("wr_addr", 64'(bus.mem_addr), 64'(a));
            chk("wr_rdy", 64'(bus.ld_ready), 64'(1));
            chk("wr_inst", 64'(bus.cpu_inst), 64'(0));
            ref_mem[a] = d;
            exp_sum = exp_sum + d;
            tick();
        end
        bus.ld_valid = 1'b0;
        @(negedge clk);
        chk("dn_done", 64'(bus.done), 64'(1));
        chk("dn_stall", 64'(bus.cpu_stall), 64'(1));
        chk("dn_rdy", 64'(bus.ld_ready), 64'(0));
        chk("dn_we", 64'(bus.mem_we), 64'(0));
        chk("dn_nwr", 64'(wr_n - w0), 64'(l));
        chk("dn_csum", 64'(bus.csum), 64'(exp_csum()));
        tick();
        @(negedge clk);
        chk("post_done", 64'(bus.done), 64'(0));
        chk("post_stall", 64'(bus.cpu_stall), 64'(0));
        chk("post_busy", 64'(bus.busy), 64'(0));
        tick();
    endtask

    task automatic reject(input logic [11:0] b, input logic [12:0] l);
        int w0;
        w0 = wr_n;
        start(b, l);
        @(negedge clk);
        chk("rj_err", 64'(bus.err), 64'(1));
        chk("rj_done", 64'(bus.done), 64'(0));
        chk("rj_busy", 64'(bus.busy), 64'(0));
        chk("rj_rdy", 64'(bus.ld_ready), 64'(0));
        tick();
        @(negedge clk);
        chk("rj_err2", 64'(bus.err), 64'(0));
        chk("rj_busy2", 64'(bus.busy), 64'(0));
        chk("rj_nwr", 64'(wr_n - w0), 64'(0));
        tick();
    endtask

    task automatic zero_len(input logic [11:0] b);
        start(b, 13'd0);
        @(negedge clk);
        chk("z_done", 64'(bus.done), 64'(1));
        chk("z_err", 64'(bus.err), 64'(0));
        chk("z_busy", 64'(bus.busy), 64'(0));
        tick();
        @(negedge clk);
        chk("z_done2", 64'(bus.done), 64'(0));
        tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'(i) * 32'h9E37 + 32'h11;
            ref_mem[i] = 32'(i) * 32'h9E37 + 32'h11;
        end
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_len   = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.cpu_addr   = '0;
        exp_sum        = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_stall", 64'(bus.cpu_stall), 64'(0));
        chk("rst_rdy", 64'(bus.ld_ready), 64'(0));
        chk("rst_we", 64'(bus.mem_we), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));
        chk("rst_csum", 64'(bus.csum), 64'(0));
        tick();

        fetch(32'd8);
        dq = '{32'hAA, 32'hBB, 32'hCC};
        do_load(12'd0, 13'd3, 1'b0);
        fetch(32'd0);
        fetch(32'd8);
        do_load(12'd10, 13'd2, 1'b1);
        fetch(32'd40);
        fetch(32'd44);
        reject(12'd4090, 13'd10);
        zero_len(12'd5);
        do_load(12'd4094, 13'd2, 1'b0);
        fetch(32'h0000_3FFC);

        // Abort after two of five words; those two must persist
        start(12'd0, 13'd5);
        for (int i = 0; i < 2; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'h5000 + 32'(i);
            ref_mem[i]   = 32'h5000 + 32'(i);
            tick();
        end
        bus.ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ab_busy", 64'(bus.busy), 64'(0));
        chk("ab_stall", 64'(bus.cpu_stall), 64'(0));
        chk("ab_done", 64'(bus.done), 64'(0));
        tick();
        @(negedge clk);
        chk("ab_done2", 64'(bus.done), 64'(0));
        tick();
        do_load(12'd100, 13'd2, 1'b1);
        fetch(32'd0);
        fetch(32'd4);
        fetch(32'd8);

        dq = '{32'h1, 32'h2, 32'hFFFF_FFFF};
        do_load(12'd200, 13'd3, 1'b0);

        for (int n = 0; n < 25; n++) begin
            int kind;
            logic [12:0] l;
            logic [11:0] b;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                zero_len(12'($urandom));
            end else if (kind == 1) begin
                b = 12'($urandom_range(4000, 4095));
                l = 13'(DEPTH - int'(b) + 1 + int'($urandom_range(0, 20)));
                reject(b, l);
            end else begin
                l = 13'($urandom_range(1, 8));
                b = 12'($urandom_range(0, DEPTH - int'(l)));
                do_load(b, l, 1'b1);
                fetch({18'd0, b, 2'b00});
            end
            fetch({18'd0, 12'($urandom), 2'b00});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
